// File: rtl/apb_wr_master_if.sv
// ---------------------------------------------------------------------------
// apb_wr_master_if
// Bundles every non-clock, non-reset signal of the APB write master:
//   - CDC FIFO read side : afifo_rvld, afifo_rrdy, afifo_rpayload {id,addr,strb,data}
//   - APB4 master bus    : PSEL_o, PENABLE_o, PWRITE_o, PPROT_o, PADDR_o,
//                          PWDATA_o, PSTRB_o, PREADY_i, PSLVERR_i
//   - response port      : resp_vld, resp_rdy, resp_id, resp_err
//   - status             : timeout_o (watchdog termination pulse)
// Signal suffixes (_i/_o) are named from the master's point of view.
// Modports: master (the apb_wr_master block), slave (FIFO/APB slave/B-channel side).
// ---------------------------------------------------------------------------
interface apb_wr_master_if #(
    parameter int ID_NUM = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    localparam int STRB_W = DATA_W / 8;
    localparam int PLD_W  = ID_NUM + ADDR_W + STRB_W + DATA_W;

    // FIFO read side
    logic              afifo_rvld;
    logic              afifo_rrdy;
    logic [PLD_W-1:0]  afifo_rpayload;

    // APB4 bus
    logic              PSEL_o;
    logic              PENABLE_o;
    logic              PWRITE_o;
    logic [2:0]        PPROT_o;
    logic [ADDR_W-1:0] PADDR_o;
    logic [DATA_W-1:0] PWDATA_o;
    logic [STRB_W-1:0] PSTRB_o;
    logic              PREADY_i;
    logic              PSLVERR_i;

    // Response port
    logic              resp_vld;
    logic              resp_rdy;
    logic [ID_NUM-1:0] resp_id;
    logic              resp_err;

    // Watchdog status
    logic              timeout_o;

    modport master (
        input  afifo_rvld, afifo_rpayload, PREADY_i, PSLVERR_i, resp_rdy,
        output afifo_rrdy, PSEL_o, PENABLE_o, PWRITE_o, PPROT_o, PADDR_o,
               PWDATA_o, PSTRB_o, resp_vld, resp_id, resp_err, timeout_o
    );

    modport slave (
        output afifo_rvld, afifo_rpayload, PREADY_i, PSLVERR_i, resp_rdy,
        input  afifo_rrdy, PSEL_o, PENABLE_o, PWRITE_o, PPROT_o, PADDR_o,
               PWDATA_o, PSTRB_o, resp_vld, resp_id, resp_err, timeout_o
    );
endinterface

// File: rtl/apb_wr_master.sv
// ---------------------------------------------------------------------------
// apb_wr_master
// Write-only APB4 master draining the AXI-side CDC FIFO. Each popped payload
// {id, addr, strb, data} becomes one APB SETUP/ACCESS write; its completion
// status {id, err} is offered on a valid/ready response port. A PREADY
// watchdog ends hung accesses with an error so the FIFO never stalls forever.
// Ports:
//   PCLK_i     : clock for the whole block
//   PRESETn_i  : synchronous active-low reset
//   bus        : apb_wr_master_if.master (FIFO read side, APB bus, response
//                port, timeout pulse)
// All outputs come straight from flops; nothing combinational from inputs.
// ---------------------------------------------------------------------------
module apb_wr_master #(
    parameter int ID_NUM      = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            PCLK_i,
    input  logic            PRESETn_i,
    apb_wr_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PLD_W  = ID_NUM + ADDR_W + STRB_W + DATA_W;
    localparam int WD_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam bit WD_EN  = (TIMEOUT_CYC != 0);
    localparam int WD_LIM = WD_EN ? (TIMEOUT_CYC - 1) : 0;
    localparam logic [WD_W-1:0] WD_LIM_V = WD_LIM[WD_W-1:0];
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [WD_W-1:0]   wd_cnt_q,   wd_cnt_d;
    logic [ADDR_W-1:0] paddr_q,    paddr_d;
    logic [DATA_W-1:0] pwdata_q,   pwdata_d;
    logic [STRB_W-1:0] pstrb_q,    pstrb_d;
    logic              psel_q,     psel_d;
    logic              penable_q,  penable_d;
    logic              rrdy_q,     rrdy_d;
    logic              resp_vld_q, resp_vld_d;
    logic [ID_NUM-1:0] resp_id_q,  resp_id_d;
    logic              resp_err_q, resp_err_d;
    logic              timeout_q,  timeout_d;

    // Payload fields, id in the MSBs
    logic [PLD_W-1:0]  pld_s;
    logic [ID_NUM-1:0] pld_id_s;
    logic [ADDR_W-1:0] pld_addr_s;
    logic [STRB_W-1:0] pld_strb_s;
    logic [DATA_W-1:0] pld_data_s;

    assign pld_s      = bus.afifo_rpayload;
    assign pld_id_s   = pld_s[PLD_W-1 -: ID_NUM];
    assign pld_addr_s = pld_s[STRB_W+DATA_W +: ADDR_W];
    assign pld_strb_s = pld_s[DATA_W +: STRB_W];
    assign pld_data_s = pld_s[DATA_W-1:0];

    // Next-state, datapath capture and registered-output decode
    always_comb begin
        state_d    = state_q;
        wd_cnt_d   = wd_cnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        resp_id_d  = resp_id_q;
        resp_err_d = resp_err_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rrdy_q is high exactly when IDLE is reached, so it doubles as the pop qualifier
                if (bus.afifo_rvld && rrdy_q) begin
                    paddr_d    = pld_addr_s;
                    pwdata_d   = pld_data_s;
                    pstrb_d    = pld_strb_s;
                    resp_id_d  = pld_id_s;
                    resp_err_d = 1'b0;
                    if (pld_strb_s != {STRB_W{1'b0}}) begin
                        state_d = ST_SETUP;
                    end else begin
                        // Nothing to write: report success without touching the bus
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                wd_cnt_d = {WD_W{1'b0}};
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.PREADY_i) begin
                    resp_err_d = bus.PSLVERR_i;
                    state_d    = ST_RESP;
                end else if (WD_EN && (wd_cnt_q == WD_LIM_V)) begin
                    resp_err_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    // Saturate so a disabled watchdog cannot wrap the counter
                    if (wd_cnt_q != {WD_W{1'b1}}) begin
                        wd_cnt_d = wd_cnt_q + WD_ONE;
                    end else begin
                        wd_cnt_d = wd_cnt_q;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (resp_vld_q && bus.resp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus controls are decoded from the next state so they appear registered
        psel_d     = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d  = (state_d == ST_ACCESS);
        rrdy_d     = (state_d == ST_IDLE);
        resp_vld_d = (state_d == ST_RESP);
    end

    // State, watchdog, datapath and output registers with synchronous reset
    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            state_q    <= ST_IDLE;
            wd_cnt_q   <= {WD_W{1'b0}};
            paddr_q    <= {ADDR_W{1'b0}};
            pwdata_q   <= {DATA_W{1'b0}};
            pstrb_q    <= {STRB_W{1'b0}};
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            rrdy_q     <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_id_q  <= {ID_NUM{1'b0}};
            resp_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_cnt_q   <= wd_cnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            rrdy_q     <= rrdy_d;
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
            resp_err_q <= resp_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.afifo_rrdy = rrdy_q;
    assign bus.PSEL_o     = psel_q;
    assign bus.PENABLE_o  = penable_q;
    assign bus.PWRITE_o   = 1'b1;
    assign bus.PPROT_o    = 3'b000;
    assign bus.PADDR_o    = paddr_q;
    assign bus.PWDATA_o   = pwdata_q;
    assign bus.PSTRB_o    = pstrb_q;
    assign bus.resp_vld   = resp_vld_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_apb_wr_master.sv
// ---------------------------------------------------------------------------
// tb_apb_wr_master
// Self-checking bench for apb_wr_master (TIMEOUT_CYC = 8). A FIFO model feeds
// payloads, an APB slave model inserts wait states / errors, and a negedge
// monitor checks APB address/data against a queue and responses against a
// scoreboard filled when each payload is queued.
// ---------------------------------------------------------------------------
module tb_apb_wr_master;
    localparam int ID_NUM      = 4;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 8;
    localparam int STRB_W      = DATA_W / 8;
    localparam int PLD_W       = ID_NUM + ADDR_W + STRB_W + DATA_W;

    typedef struct {
        logic [ID_NUM-1:0] id;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        int                waits;
        logic              slverr;
        logic              exp_err;
        int                exp_psel;
        int                exp_pen;
        int                exp_lat;
        int                exp_to;
    } vec_t;

    typedef struct {
        logic [ID_NUM-1:0] id;
        logic              err;
    } rsp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } apb_t;

    logic clk;
    logic rst_n;

    apb_wr_master_if #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_wr_master #(
        .ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK_i    (clk),
        .PRESETn_i (rst_n),
        .bus       (bus)
    );

    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   rsp_cnt  = 0;
    int   psel_cnt = 0;
    int   pen_cnt  = 0;
    int   to_cnt   = 0;
    int   pop_cyc  = 0;
    int   lat      = -1;
    int   cur_wait = 0;
    int   acc_n    = 0;
    logic cur_err  = 1'b0;
    logic pop_flag = 1'b0;
    logic vld_prev = 1'b0;
    rsp_t e_rsp;

    logic [PLD_W-1:0] pld_q[$];
    rsp_t             exp_q[$];
    apb_t             apb_q[$];

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // FIFO model: retire the head after a pop, present the next head
    always @(posedge clk) begin
        #1;
        if (pop_flag) begin
            pop_flag = 1'b0;
            if (pld_q.size() > 0) void'(pld_q.pop_front());
        end
        bus.afifo_rvld     = (pld_q.size() > 0);
        bus.afifo_rpayload = (pld_q.size() > 0) ? pld_q[0] : '0;
    end

    // APB slave model: PREADY after cur_wait ACCESS cycles; random noise elsewhere
    always @(posedge clk) begin
        #1;
        if (bus.PSEL_o && bus.PENABLE_o) begin
            if (acc_n >= cur_wait) begin
                bus.PREADY_i  = 1'b1;
                bus.PSLVERR_i = cur_err;
            end else begin
                bus.PREADY_i  = 1'b0;
                bus.PSLVERR_i = 1'($urandom_range(0, 1));
            end
            acc_n++;
        end else begin
            acc_n         = 0;
            bus.PREADY_i  = 1'($urandom_range(0, 1));
            bus.PSLVERR_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: APB stability, counters, latency and response scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.afifo_rvld && bus.afifo_rrdy) begin
                pop_flag = 1'b1;
                pop_cyc  = cyc;
            end
            if (bus.PSEL_o) begin
                psel_cnt++;
                if (apb_q.size() == 0) begin
                    flag("psel_without_beat");
                end else begin
                    chk("paddr",  64'(bus.PADDR_o),  64'(apb_q[0].addr));
                    chk("pwdata", 64'(bus.PWDATA_o), 64'(apb_q[0].data));
                    chk("pstrb",  64'(bus.PSTRB_o),  64'(apb_q[0].strb));
                end
            end
            if (bus.PENABLE_o) pen_cnt++;
            if (bus.PSEL_o && bus.PENABLE_o && bus.PREADY_i && apb_q.size() > 0)
                void'(apb_q.pop_front());
            if (bus.timeout_o) begin
                to_cnt++;
                if (apb_q.size() > 0) void'(apb_q.pop_front());
            end
            if (bus.resp_vld && !vld_prev) lat = cyc - pop_cyc;
            if (bus.resp_vld && bus.resp_rdy) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    e_rsp = exp_q.pop_front();
                    chk("resp_id",  64'(bus.resp_id),  64'(e_rsp.id));
                    chk("resp_err", 64'(bus.resp_err), 64'(e_rsp.err));
                end
            end
            vld_prev = bus.resp_vld;
        end else begin
            vld_prev = 1'b0;
        end
    end

    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_cnt < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (rsp_cnt < n) flag({name, "_resp_bound"});
    endtask

    task automatic push_beat(input logic [ID_NUM-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [STRB_W-1:0] strb, input logic [DATA_W-1:0] data,
                             input logic exp_err);
        rsp_t r;
        apb_t a;
        r.id  = id;
        r.err = exp_err;
        a.addr = addr;
        a.data = data;
        a.strb = strb;
        pld_q.push_back({id, addr, strb, data});
        exp_q.push_back(r);
        if (strb != '0) apb_q.push_back(a);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    base;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        psel_cnt = 0;
        pen_cnt  = 0;
        to_cnt   = 0;
        lat      = -1;
        cur_wait = v.waits;
        cur_err  = v.slverr;
        base     = rsp_cnt;
        push_beat(v.id, v.addr, v.strb, v.data, v.exp_err);
        wait_rsp(base + 1, nm);
        chk({nm, "_psel_cycles"},    64'(psel_cnt), 64'(v.exp_psel));
        chk({nm, "_penable_cycles"}, 64'(pen_cnt),  64'(v.exp_pen));
        chk({nm, "_latency"},        64'(lat),      64'(v.exp_lat));
        chk({nm, "_timeout_pulses"}, 64'(to_cnt),   64'(v.exp_to));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int k;
        int base;

        // {id, addr, strb, data, waits, slverr, exp_err, psel, penable, latency, timeouts}
        vecs[0] = '{4'h3, 12'h010, 4'hF, 32'hDEADBEEF,    0, 1'b0, 1'b0, 2, 1,  3, 0};
        vecs[1] = '{4'h1, 12'h024, 4'h3, 32'h12345678,    3, 1'b1, 1'b1, 5, 4,  6, 0};
        vecs[2] = '{4'h7, 12'hFFC, 4'h8, 32'hA5A5A5A5, 1000, 1'b0, 1'b1, 9, 8, 10, 1};
        vecs[3] = '{4'h5, 12'h100, 4'h0, 32'h0BADF00D,    0, 1'b1, 1'b0, 0, 0,  1, 0};
        vecs[4] = '{4'hF, 12'h000, 4'h1, 32'h00000001,    7, 1'b0, 1'b0, 9, 8, 10, 0};
        vecs[5] = '{4'h2, 12'h7F0, 4'h6, 32'h5A5A0F0F,    2, 1'b0, 1'b0, 4, 3,  5, 0};
        vecs[6] = '{4'h4, 12'h0AC, 4'hF, 32'h600DCAFE,    0, 1'b0, 1'b0, 2, 1,  3, 0};

        rst_n        = 1'b0;
        bus.resp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_afifo_rrdy", 64'(bus.afifo_rrdy), 64'd0);
        chk("rst_psel",       64'(bus.PSEL_o),     64'd0);
        chk("rst_penable",    64'(bus.PENABLE_o),  64'd0);
        chk("rst_pwrite",     64'(bus.PWRITE_o),   64'd1);
        chk("rst_pprot",      64'(bus.PPROT_o),    64'd0);
        chk("rst_paddr",      64'(bus.PADDR_o),    64'd0);
        chk("rst_resp_vld",   64'(bus.resp_vld),   64'd0);
        chk("rst_timeout",    64'(bus.timeout_o),  64'd0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_afifo_rrdy", 64'(bus.afifo_rrdy), 64'd1);

        // Table-driven single beats
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Response backpressure with three queued beats
        @(posedge clk);
        #1;
        bus.resp_rdy = 1'b0;
        cur_wait     = 0;
        cur_err      = 1'b0;
        base         = rsp_cnt;
        push_beat(4'hA, 12'h200, 4'hF, 32'h11111111, 1'b0);
        push_beat(4'hB, 12'h204, 4'hF, 32'h22222222, 1'b0);
        push_beat(4'hC, 12'h208, 4'hF, 32'h33333333, 1'b0);
        k = 0;
        while (!bus.resp_vld && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.resp_vld) flag("bp_first_resp_bound");
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_vld",   64'(bus.resp_vld),   64'd1);
            chk("bp_afifo_rrdy", 64'(bus.afifo_rrdy), 64'd0);
            chk("bp_resp_id",    64'(bus.resp_id),    64'hA);
        end
        @(posedge clk);
        #1;
        bus.resp_rdy = 1'b1;
        wait_rsp(base + 3, "bp");
        repeat (2) @(posedge clk);

        // Reset during a wait-stated ACCESS
        @(posedge clk);
        #1;
        cur_wait = 1000;
        cur_err  = 1'b0;
        push_beat(4'h9, 12'h3C0, 4'hF, 32'hCAFE0001, 1'b0);
        k = 0;
        while (!(bus.PSEL_o && bus.PENABLE_o) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!(bus.PSEL_o && bus.PENABLE_o)) flag("rst_access_bound");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        base  = rsp_cnt;
        @(posedge clk);
        @(negedge clk);
        chk("abort_psel",       64'(bus.PSEL_o),     64'd0);
        chk("abort_penable",    64'(bus.PENABLE_o),  64'd0);
        chk("abort_afifo_rrdy", 64'(bus.afifo_rrdy), 64'd0);
        chk("abort_resp_vld",   64'(bus.resp_vld),   64'd0);
        chk("abort_paddr",      64'(bus.PADDR_o),    64'd0);
        chk("abort_pwdata",     64'(bus.PWDATA_o),   64'd0);
        chk("abort_pstrb",      64'(bus.PSTRB_o),    64'd0);
        chk("abort_pwrite",     64'(bus.PWRITE_o),   64'd1);
        chk("abort_timeout",    64'(bus.timeout_o),  64'd0);
        // The aborted beat must never be answered
        exp_q.delete();
        apb_q.delete();
        @(posedge clk);
        #1;
        cur_wait = 0;
        rst_n    = 1'b1;
        repeat (6) @(posedge clk);
        chk("abort_no_resp", 64'(rsp_cnt), 64'(base));
        run_vec(vecs[6], 6);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_time_bound");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "time bound expired");
    end

endmodule
